// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result bundle for the bit-serial adder.
//   master : drives start, a, b, cin, sub; observes sum, cout, ovf, busy, done
//   slave  : the adder itself (inverse directions)
// WIDTH must match the WIDTH of the serial_adder it is connected to.
interface serial_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;
    logic             done;

    modport master (
        output start, a, b, cin, sub,
        input  sum, cout, ovf, busy, done
    );

    modport slave (
        input  start, a, b, cin, sub,
        output sum, cout, ovf, busy, done
    );
endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial add/subtract, one bit per cycle, LSB first.
//   clk        : rising-edge clock
//   rst_n      : synchronous active-low reset
//   bus.start  : request; accepted in IDLE or DONE, ignored while busy
//   bus.a/b    : operands, latched at acceptance
//   bus.cin    : carry-in (add) / borrow-in (subtract), latched at acceptance
//   bus.sub    : 0 = a+b+cin, 1 = a-b-cin
//   bus.sum    : registered result, updated only on entry to DONE
//   bus.cout   : registered carry-out of MSB (subtract: 1 = no borrow)
//   bus.ovf    : registered signed overflow
//   bus.busy   : high while bits are being processed
//   bus.done   : one-cycle pulse when sum/cout/ovf have just updated
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input logic           clk,
    input logic           rst_n,
    serial_adder_if.slave bus
);
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             s_bit;
    logic             c_next;
    logic             last_bit;
    logic [WIDTH-1:0] res_next;

    always_comb begin
        s_bit    = a_q[0] ^ b_q[0] ^ c_q;
        c_next   = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
        last_bit = (cnt_q == CntW'(WIDTH - 1));
        // Result enters at the MSB and walks down, so after WIDTH shifts bit 0 is in place.
        res_next = (res_q >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));

        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        c_d     = c_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    // Subtract as a + ~b + ~borrow: two's complement with the borrow folded in.
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    c_d     = bus.cin ^ bus.sub;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = c_next;
                res_d = res_next;
                cnt_d = cnt_q + CntW'(1);
                if (last_bit) begin
                    // c_q is the carry into the MSB here, c_next the carry out of it.
                    sum_d   = res_next;
                    cout_d  = c_next;
                    ovf_d   = c_q ^ c_next;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            c_q     <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            c_q     <= c_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
    assign bus.busy = (state_q == StRun);
    assign bus.done = (state_q == StDone);
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed checks of serial_adder at WIDTH=8 and WIDTH=1.
// Inputs change #1 after a rising edge and outputs are sampled there too; an
// edge "n" below counts from the edge at which start is first driven as edge 0.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) bus8 ();
    serial_adder_if #(.WIDTH(1)) bus1 ();

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start must already be driven; the first tick is the accepting edge.
    task automatic wait_done8(input bit hold_start, output int n, output int busy_n);
        n      = 0;
        busy_n = 0;
        do begin
            tick();
            n++;
            if (!hold_start) bus8.start = 1'b0;
            if (bus8.busy) busy_n++;
        end while (!bus8.done && n < 30);
    endtask

    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic sub, input logic [7:0] es,
                       input logic ec, input logic eo);
        int n;
        int bn;
        bus8.a     = a;
        bus8.b     = b;
        bus8.cin   = cin;
        bus8.sub   = sub;
        bus8.start = 1'b1;
        wait_done8(1'b0, n, bn);
        check({tag, "_latency"}, 64'(n), 64'd9);
        check({tag, "_busy_cycles"}, 64'(bn), 64'd8);
        check({tag, "_sum"}, 64'(bus8.sum), 64'(es));
        check({tag, "_cout"}, 64'(bus8.cout), 64'(ec));
        check({tag, "_ovf"}, 64'(bus8.ovf), 64'(eo));
        tick();
        check({tag, "_done_pulse"}, 64'(bus8.done), 64'd0);
    endtask

    task automatic op1(input string tag, input logic a, input logic b, input logic cin,
                       input logic sub, input logic es, input logic ec, input logic eo);
        int n;
        bus1.a     = a;
        bus1.b     = b;
        bus1.cin   = cin;
        bus1.sub   = sub;
        bus1.start = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
            bus1.start = 1'b0;
        end while (!bus1.done && n < 30);
        check({tag, "_latency"}, 64'(n), 64'd2);
        check({tag, "_sum"}, 64'(bus1.sum), 64'(es));
        check({tag, "_cout"}, 64'(bus1.cout), 64'(ec));
        check({tag, "_ovf"}, 64'(bus1.ovf), 64'(eo));
        tick();
    endtask

    initial begin
        int n;
        int bn;
        int m;
        int extra;

        rst_n      = 1'b0;
        bus8.start = 1'b0;
        bus8.a     = '0;
        bus8.b     = '0;
        bus8.cin   = 1'b0;
        bus8.sub   = 1'b0;
        bus1.start = 1'b0;
        bus1.a     = '0;
        bus1.b     = '0;
        bus1.cin   = 1'b0;
        bus1.sub   = 1'b0;
        repeat (2) tick();
        check("rst_busy", 64'(bus8.busy), 64'd0);
        check("rst_done", 64'(bus8.done), 64'd0);
        check("rst_sum", 64'(bus8.sum), 64'd0);
        check("rst_cout", 64'(bus8.cout), 64'd0);
        check("rst_ovf", 64'(bus8.ovf), 64'd0);

        // Released right before the edge that must accept the first start.
        rst_n = 1'b1;
        op8("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        op8("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        op8("add_80_ff", 8'h80, 8'hFF, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b1);
        op8("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
        op8("sub_10_03_b", 8'h10, 8'h03, 1'b1, 1'b1, 8'h0C, 1'b1, 1'b0);
        op8("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
        op8("add_3c_0a_c", 8'h3C, 8'h0A, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0);

        // Start pulse and operand/mode changes mid-RUN must be ignored.
        bus8.a     = 8'h12;
        bus8.b     = 8'h34;
        bus8.cin   = 1'b0;
        bus8.sub   = 1'b0;
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        tick();
        tick();
        bus8.start = 1'b1;
        bus8.a     = 8'hFF;
        bus8.b     = 8'hFF;
        bus8.cin   = 1'b1;
        bus8.sub   = 1'b1;
        tick();
        bus8.start = 1'b0;
        n = 4;
        while (!bus8.done && n < 30) begin
            tick();
            n++;
        end
        check("ignore_latency", 64'(n), 64'd9);
        check("ignore_sum", 64'(bus8.sum), 64'h46);
        check("ignore_cout", 64'(bus8.cout), 64'd0);
        check("ignore_ovf", 64'(bus8.ovf), 64'd0);
        extra = 0;
        repeat (12) begin
            tick();
            if (bus8.done) extra++;
        end
        check("ignore_extra_done", 64'(extra), 64'd0);

        // Back-to-back: start held high through DONE.
        bus8.a     = 8'h01;
        bus8.b     = 8'h02;
        bus8.cin   = 1'b0;
        bus8.sub   = 1'b0;
        bus8.start = 1'b1;
        wait_done8(1'b1, n, bn);
        check("b2b_first_latency", 64'(n), 64'd9);
        check("b2b_first_sum", 64'(bus8.sum), 64'h03);
        bus8.a = 8'h40;
        bus8.b = 8'h40;
        tick();
        check("b2b_no_gap_busy", 64'(bus8.busy), 64'd1);
        bus8.start = 1'b0;
        m = 1;
        while (!bus8.done && m < 30) begin
            tick();
            m++;
        end
        check("b2b_spacing", 64'(m), 64'd9);
        check("b2b_second_sum", 64'(bus8.sum), 64'h80);
        check("b2b_second_cout", 64'(bus8.cout), 64'd0);
        check("b2b_second_ovf", 64'(bus8.ovf), 64'd1);
        tick();

        // Reset in RUN cycle 4 aborts the operation.
        bus8.a     = 8'hAA;
        bus8.b     = 8'h55;
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_busy", 64'(bus8.busy), 64'd0);
        check("abort_done", 64'(bus8.done), 64'd0);
        check("abort_sum", 64'(bus8.sum), 64'd0);
        check("abort_cout", 64'(bus8.cout), 64'd0);
        check("abort_ovf", 64'(bus8.ovf), 64'd0);
        extra = 0;
        repeat (20) begin
            tick();
            if (bus8.done) extra++;
        end
        check("abort_no_done", 64'(extra), 64'd0);
        op8("after_abort", 8'hAA, 8'h55, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);

        // Single-bit instance.
        op1("w1_add_111", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        op1("w1_sub_0_1", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
